// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder.
//   state_t : sequencer states (IDLE, RUN, DONE); encoding 2'd3 is unused
//   NIB_W   : width of one CLA pass in bits
//   clog2   : ceiling log2, used to size the nibble index
package cla_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    int unsigned v;
    w = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/cla_adder_4.sv
// 4-bit carry-lookahead adder, purely combinational.
//   a_in, b_in : 4-bit operands
//   c_in       : carry-in
//   sum_out    : {carry-out, sum[3:0]}
module cla_adder_4 (
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic       c_in,
  output logic [4:0] sum_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a_in & b_in;
    p    = a_in ^ b_in;
    c    = '0;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
    sum_out = {c[4], p ^ c[3:0]};
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Nibble-serial adder: accepts WIDTH-bit operands over a valid/ready
// handshake, adds one nibble per clock through a single cla_adder_4 with the
// carry rippled through a register, and presents {carry-out, sum} over a
// second valid/ready handshake.
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_valid_in   : operands offered       in_ready_out  : idle, can accept
//   a_in, b_in    : WIDTH-bit operands     c_in          : carry-in
//   out_valid_out : result available       out_ready_in  : consumer accepts
//   sum_out       : WIDTH+1 bit result     busy_out      : addition running
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [WIDTH:0]   sum_out,
  output logic             busy_out
);

  localparam int unsigned NIBBLES = WIDTH / NIB_W;
  localparam int unsigned IDX_W   = (clog2(NIBBLES) == 0) ? 1 : clog2(NIBBLES);

  if (WIDTH == 0 || (WIDTH % NIB_W) != 0) begin : g_width_check
    $error("cla_seq_adder: WIDTH must be a positive multiple of 4");
  end

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               carry_reg;
  logic [IDX_W-1:0]   nib_idx;
  logic [WIDTH:0]     res;
  logic [NIB_W-1:0]   a_nib;
  logic [NIB_W-1:0]   b_nib;
  logic [NIB_W:0]     cla_sum;
  logic               is_last;

  // Nibble select written as a constant-index loop so every slice is static.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (nib_idx == IDX_W'(i)) begin
        a_nib = a_reg[i*NIB_W +: NIB_W];
        b_nib = b_reg[i*NIB_W +: NIB_W];
      end
    end
    is_last = (nib_idx == IDX_W'(NIBBLES - 1));
  end

  cla_adder_4 u_cla (
    .a_in    (a_nib),
    .b_in    (b_nib),
    .c_in    (carry_reg),
    .sum_out (cla_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    in_ready_out  = 1'b0;
    out_valid_out = 1'b0;
    busy_out      = 1'b0;
    sum_out       = res;
    case (state)
      ST_IDLE: begin
        in_ready_out = 1'b1;
        if (in_valid_in) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy_out = 1'b1;
        if (is_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid_out = 1'b1;
        if (out_ready_in) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      nib_idx   <= '0;
      res       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid_in) begin
            a_reg     <= a_in;
            b_reg     <= b_in;
            carry_reg <= c_in;
            nib_idx   <= '0;
            res       <= '0;
          end
        end
        ST_RUN: begin
          for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (nib_idx == IDX_W'(i)) res[i*NIB_W +: NIB_W] <= cla_sum[NIB_W-1:0];
          end
          carry_reg <= cla_sum[NIB_W];
          if (is_last) begin
            res[WIDTH] <= cla_sum[NIB_W];
          end else begin
            nib_idx <= nib_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: three instances (WIDTH 4, 16, 32) share one
// stimulus bus; sel routes the handshakes to one of them at a time.
module tb_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel;
  logic        in_valid, out_ready, cin;
  logic [31:0] a, b;

  logic        ir4, ov4, bz4, ir16, ov16, bz16, ir32, ov32, bz32;
  logic [4:0]  s4;
  logic [16:0] s16;
  logic [32:0] s32;

  logic        ir, ov, bz;
  logic [32:0] sum;

  int unsigned cur_w;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid_in(in_valid && sel == 2'd0), .in_ready_out(ir4),
    .a_in(a[3:0]), .b_in(b[3:0]), .c_in(cin), .out_valid_out(ov4),
    .out_ready_in(out_ready && sel == 2'd0), .sum_out(s4), .busy_out(bz4)
  );

  cla_seq_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid_in(in_valid && sel == 2'd1), .in_ready_out(ir16),
    .a_in(a[15:0]), .b_in(b[15:0]), .c_in(cin), .out_valid_out(ov16),
    .out_ready_in(out_ready && sel == 2'd1), .sum_out(s16), .busy_out(bz16)
  );

  cla_seq_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid_in(in_valid && sel == 2'd2), .in_ready_out(ir32),
    .a_in(a), .b_in(b), .c_in(cin), .out_valid_out(ov32),
    .out_ready_in(out_ready && sel == 2'd2), .sum_out(s32), .busy_out(bz32)
  );

  always_comb begin
    case (sel)
      2'd0:    begin ir = ir4;  ov = ov4;  bz = bz4;  sum = {28'd0, s4};  end
      2'd1:    begin ir = ir16; ov = ov16; bz = bz16; sum = {16'd0, s16}; end
      default: begin ir = ir32; ov = ov32; bz = bz32; sum = s32;          end
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (width %0d, t=%0t)", name, act, exp, cur_w, $time);
    end
  endtask

  function automatic logic [63:0] expect_sum(input logic [31:0] x, input logic [31:0] y,
                                             input logic c, input int unsigned w);
    logic [63:0] opmask, resmask;
    opmask  = (64'd1 << w) - 64'd1;
    resmask = (64'd1 << (w + 1)) - 64'd1;
    return ((64'(x) & opmask) + (64'(y) & opmask) + 64'(c)) & resmask;
  endfunction

  // Transaction-level model: an accepted operation is pending until consumed;
  // m_j counts edges since acceptance (RUN while below NIBBLES, DONE after).
  logic        m_pending;
  int unsigned m_j;
  logic [32:0] m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 1'b0;
      m_j       <= 0;
      m_exp     <= '0;
    end else if (!m_pending) begin
      if (in_valid) begin
        m_pending <= 1'b1;
        m_j       <= 0;
        m_exp     <= 33'(expect_sum(a, b, cin, cur_w));
      end
    end else begin
      if (m_j >= cur_w / 4) begin
        if (out_ready) m_pending <= 1'b0;
      end else begin
        m_j <= m_j + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready", 64'(ir), 64'd1);
      check("rst_out_valid", 64'(ov), 64'd0);
      check("rst_busy", 64'(bz), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
    end else begin
      check("mdl_in_ready", 64'(ir), 64'(!m_pending));
      check("mdl_busy", 64'(bz), 64'(m_pending && m_j < cur_w / 4));
      check("mdl_out_valid", 64'(ov), 64'(m_pending && m_j >= cur_w / 4));
      if (m_pending && m_j >= cur_w / 4) check("mdl_sum", 64'(sum), 64'(m_exp));
    end
  end

  // Runs one operation starting just after a rising edge; returns the result,
  // the accept-to-valid latency and the number of busy cycles observed.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                        input int stall, input bit churn,
                        output logic [32:0] res, output int lat, output int busy_cnt);
    int guard;
    guard = 0;
    while (!ir && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_ready", 64'(ir), 64'd1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!ov && lat < 100) begin
      if (bz) busy_cnt++;
      if (churn) begin
        a = $urandom; b = $urandom; cin = 1'($urandom); out_ready = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    check("valid_seen", 64'(ov), 64'd1);
    res = sum;
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      check("hold_valid", 64'(ov), 64'd1);
      check("hold_sum", 64'(sum), 64'(res));
      check("hold_no_ready", 64'(ir), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic set_width(input logic [1:0] s, input int unsigned w);
    rst_n = 1'b0;
    sel = s;
    cur_w = w;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic random_ops(input int n);
    logic [31:0] ta, tb;
    logic        tc;
    logic [32:0] r;
    int          lat, bc;
    for (int i = 0; i < n; i++) begin
      ta = $urandom; tb = $urandom; tc = 1'($urandom);
      run_op(ta, tb, tc, int'($urandom_range(0, 3)), 1'b1, r, lat, bc);
      check("rand_sum", 64'(r), expect_sum(ta, tb, tc, cur_w));
      check("rand_latency", 64'(lat), 64'(cur_w / 4));
    end
  endtask

  logic [32:0] r;
  int          lat, bc;

  initial begin
    sel = 2'd1; cur_w = 16;
    in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; a = '0; b = '0;
    #2;
    check("init_in_ready", 64'(ir), 64'd1);
    check("init_sum", 64'(sum), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'h1234, 32'h4321, 1'b0, 0, 1'b0, r, lat, bc);
    check("basic_sum", 64'(r), 64'h05555);
    check("basic_latency", 64'(lat), 64'd4);
    check("basic_busy_cycles", 64'(bc), 64'd4);

    run_op(32'hFFFF, 32'h0001, 1'b0, 0, 1'b0, r, lat, bc);
    check("carry_chain", 64'(r), 64'h10000);
    run_op(32'hFFFF, 32'hFFFF, 1'b1, 0, 1'b0, r, lat, bc);
    check("all_ones_cin", 64'(r), 64'h1FFFF);

    run_op(32'h00AA, 32'h0055, 1'b1, 10, 1'b0, r, lat, bc);
    check("backpressure_sum", 64'(r), 64'h00100);
    check("post_handshake_ready", 64'(ir), 64'd1);

    run_op(32'hABCD, 32'h1111, 1'b1, 2, 1'b1, r, lat, bc);
    check("churn_sum", 64'(r), 64'h0BCDF);

    a = 32'h8888; b = 32'h8888; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_ready", 64'(ir), 64'd1);
    check("midrun_rst_valid", 64'(ov), 64'd0);
    check("midrun_rst_busy", 64'(bz), 64'd0);
    check("midrun_rst_sum", 64'(sum), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h0001, 32'h0001, 1'b0, 0, 1'b0, r, lat, bc);
    check("after_rst_sum", 64'(r), 64'h00002);

    random_ops(200);

    set_width(2'd0, 4);
    run_op(32'hF, 32'hF, 1'b1, 1, 1'b0, r, lat, bc);
    check("w4_sum", 64'(r), 64'h1F);
    check("w4_latency", 64'(lat), 64'd1);
    check("w4_busy_cycles", 64'(bc), 64'd1);
    random_ops(200);

    set_width(2'd2, 32);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, r, lat, bc);
    check("w32_sum", 64'(r), 64'h1_0000_0000);
    check("w32_latency", 64'(lat), 64'd8);
    random_ops(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
